// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Next-PC predictor: direct-mapped BTB with 2-bit counters + RAS.
// Revision : 1.0  initial release
// ============================================================================
module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  output logic            pred_hit_o,
  input  logic            upd_en_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  input  logic [1:0]      upd_kind_i,
  output logic            ras_empty_o
);

  localparam int c_IDX  = $clog2(ENTRIES);
  localparam int c_TAGW = XLEN - c_IDX - 2;
  localparam int c_PTRW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int c_CNTW = $clog2(RAS_DEPTH + 1);
  localparam logic [c_PTRW-1:0] c_PTR_LAST = c_PTRW'(RAS_DEPTH - 1);
  localparam logic [c_CNTW-1:0] c_CNT_FULL = c_CNTW'(RAS_DEPTH);
  localparam logic [1:0]        c_KIND_BR   = 2'b00;
  localparam logic [1:0]        c_KIND_JMP  = 2'b01;
  localparam logic [1:0]        c_KIND_CALL = 2'b10;
  localparam logic [1:0]        c_KIND_RET  = 2'b11;
  localparam logic [XLEN-1:0]   c_FOUR      = XLEN'(4);

  logic              r_valid  [ENTRIES];
  logic [c_TAGW-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]   r_target [ENTRIES];
  logic [1:0]        r_kind   [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];

  logic [XLEN-1:0]   r_ras    [RAS_DEPTH];
  logic [c_PTRW-1:0] r_ras_ptr;
  logic [c_CNTW-1:0] r_ras_cnt;

  logic [c_IDX-1:0]  w_idx;
  logic [c_TAGW-1:0] w_tag;
  logic              w_hit;
  logic [c_IDX-1:0]  w_upd_idx;
  logic [c_TAGW-1:0] w_upd_tag;
  logic              w_upd_hit;
  logic [1:0]        w_new_ctr;
  logic              w_write_target;
  logic [c_PTRW-1:0] w_ptr_inc;
  logic [c_PTRW-1:0] w_top_ptr;
  logic              w_ras_empty;

  assign w_idx       = pc_i[c_IDX+1:2];
  assign w_tag       = pc_i[XLEN-1:c_IDX+2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ras_empty = (r_ras_cnt == '0);
  assign w_ptr_inc   = (r_ras_ptr == c_PTR_LAST) ? '0 : r_ras_ptr + 1'b1;
  assign w_top_ptr   = (r_ras_ptr == '0) ? c_PTR_LAST : r_ras_ptr - 1'b1;

  assign pred_hit_o  = w_hit;
  assign ras_empty_o = w_ras_empty;

  // Fall-through is pc+4; any hit that predicts a redirect overrides it.
  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = pc_i + c_FOUR;
    if (w_hit) begin
      case (r_kind[w_idx])
        c_KIND_BR: begin
          if (r_ctr[w_idx][1]) begin
            pred_taken_o  = 1'b1;
            pred_target_o = r_target[w_idx];
          end
        end
        c_KIND_JMP, c_KIND_CALL: begin
          pred_taken_o  = 1'b1;
          pred_target_o = r_target[w_idx];
        end
        default: begin
          if (!w_ras_empty) begin
            pred_taken_o  = 1'b1;
            pred_target_o = r_ras[w_top_ptr];
          end
        end
      endcase
    end
  end

  assign w_upd_idx = upd_pc_i[c_IDX+1:2];
  assign w_upd_tag = upd_pc_i[XLEN-1:c_IDX+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // A not-taken branch hit keeps its old target so a later re-train still jumps right.
  assign w_write_target = !w_upd_hit || (upd_kind_i != c_KIND_BR) || upd_taken_i;

  always_comb begin
    w_new_ctr = r_ctr[w_upd_idx];
    if (!w_upd_hit) begin
      w_new_ctr = ((upd_kind_i != c_KIND_BR) || upd_taken_i) ? 2'b10 : 2'b01;
    end else if (upd_kind_i != c_KIND_BR) begin
      w_new_ctr = 2'b11;
    end else if (upd_taken_i) begin
      if (r_ctr[w_upd_idx] != 2'b11) w_new_ctr = r_ctr[w_upd_idx] + 2'b01;
    end else begin
      if (r_ctr[w_upd_idx] != 2'b00) w_new_ctr = r_ctr[w_upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_kind[i]   <= c_KIND_BR;
        r_ctr[i]    <= 2'b01;
      end
    end else if (upd_en_i) begin
      r_valid[w_upd_idx] <= 1'b1;
      r_tag[w_upd_idx]   <= w_upd_tag;
      r_kind[w_upd_idx]  <= upd_kind_i;
      r_ctr[w_upd_idx]   <= w_new_ctr;
      if (w_write_target) r_target[w_upd_idx] <= upd_target_i;
    end
  end

  // Circular stack: a push when full silently overwrites the oldest slot.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (upd_en_i) begin
      if (upd_kind_i == c_KIND_CALL) begin
        r_ras[r_ras_ptr] <= upd_pc_i + c_FOUR;
        r_ras_ptr        <= w_ptr_inc;
        if (r_ras_cnt != c_CNT_FULL) r_ras_cnt <= r_ras_cnt + 1'b1;
      end else if ((upd_kind_i == c_KIND_RET) && !w_ras_empty) begin
        r_ras_ptr <= w_top_ptr;
        r_ras_cnt <= r_ras_cnt - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Bench for branch_predictor: array/queue reference model + literals.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_predictor;
  localparam int XLEN      = 32;
  localparam int ENTRIES   = 16;
  localparam int RAS_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [1:0]  upd_kind;
  logic        ras_empty;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .pc_i          (pc),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target),
    .pred_hit_o    (pred_hit),
    .upd_en_i      (upd_en),
    .upd_pc_i      (upd_pc),
    .upd_target_i  (upd_target),
    .upd_taken_i   (upd_taken),
    .upd_kind_i    (upd_kind),
    .ras_empty_o   (ras_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  bit          lit_en = 1'b0;
  logic        lit_hit, lit_taken, lit_empty;
  logic [31:0] lit_target;

  // Reference model: plain arrays for the table, a queue for the return stack.
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  logic [1:0]  m_kind  [ENTRIES];
  int          m_ctr   [ENTRIES];
  logic [31:0] m_ras[$];

  logic        e_hit, e_taken, e_empty;
  logic [31:0] e_tgt;

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[31:2]) % ENTRIES;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / 32'(4 * ENTRIES);
  endfunction

  function automatic logic [1:0] kind_of(input logic [31:0] a);
    return a[3:2] ^ a[7:6];
  endfunction

  task automatic model_predict(input logic [31:0] a, output logic h, output logic t,
                               output logic [31:0] tg);
    int i;
    i  = idx_of(a);
    h  = m_valid[i] && (m_tag[i] == tag_of(a));
    t  = 1'b0;
    tg = a + 32'd4;
    if (h) begin
      case (m_kind[i])
        2'd0: if (m_ctr[i] >= 2) begin t = 1'b1; tg = m_tgt[i]; end
        2'd1, 2'd2: begin t = 1'b1; tg = m_tgt[i]; end
        default: if (m_ras.size() > 0) begin t = 1'b1; tg = m_ras[$]; end
      endcase
    end
  endtask

  task automatic model_update();
    int i;
    bit h;
    i = idx_of(upd_pc);
    h = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
    if (!h) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tag_of(upd_pc);
      m_kind[i]  = upd_kind;
      m_tgt[i]   = upd_target;
      m_ctr[i]   = (upd_kind != 2'd0 || upd_taken) ? 2 : 1;
    end else if (upd_kind == 2'd0) begin
      if (upd_taken) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = upd_target;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
      m_kind[i] = 2'd0;
    end else begin
      m_tgt[i]  = upd_target;
      m_kind[i] = upd_kind;
      m_ctr[i]  = 3;
    end
    if (upd_kind == 2'd2) begin
      m_ras.push_back(upd_pc + 32'd4);
      if (m_ras.size() > RAS_DEPTH) m_ras.delete(0);
    end else if (upd_kind == 2'd3 && m_ras.size() > 0) begin
      m_ras.delete(m_ras.size() - 1);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
      m_ras.delete();
    end else if (upd_en) begin
      model_update();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (pc=%h t=%0t)", name, act, exp, pc, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      model_predict(pc, e_hit, e_taken, e_tgt);
      e_empty = (m_ras.size() == 0);
      check("hit",    32'(pred_hit),   32'(e_hit));
      check("taken",  32'(pred_taken), 32'(e_taken));
      check("target", pred_target,     e_tgt);
      check("empty",  32'(ras_empty),  32'(e_empty));
      if (lit_en) begin
        check("lit_hit",    32'(pred_hit),   32'(lit_hit));
        check("lit_taken",  32'(pred_taken), 32'(lit_taken));
        check("lit_target", pred_target,     lit_target);
        check("lit_empty",  32'(ras_empty),  32'(lit_empty));
      end
    end
  end

  // One cycle: drive update + lookup just after the edge; literals describe the
  // lookup result from the state left by earlier edges.
  task automatic cyc(input bit ue, input logic [31:0] upc, input logic [31:0] ut,
                     input bit utk, input logic [1:0] uk, input logic [31:0] lpc,
                     input bit le, input bit eh, input bit et, input logic [31:0] etg,
                     input bit ee);
    @(posedge clk);
    #1;
    upd_en = ue; upd_pc = upc; upd_target = ut; upd_taken = utk; upd_kind = uk;
    pc = lpc;
    lit_en = le; lit_hit = eh; lit_taken = et; lit_target = etg; lit_empty = ee;
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 1) == 1) a = a | 32'h8000_0000;
    return a;
  endfunction

  initial begin
    upd_en = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; upd_kind = 2'd0;
    pc = 32'h100;
    lit_hit = 1'b0; lit_taken = 1'b0; lit_target = '0; lit_empty = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state and wrap of the fall-through address
    cyc(0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0, 32'h0000_0000, 1);
    cyc(0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 32'h104, 1);
    // counter training (update visible one cycle later)
    cyc(1, 32'h100, 32'h80, 1, 2'd0, 32'h100, 1, 0, 0, 32'h104, 1);
    cyc(1, 32'h100, 32'h80, 0, 2'd0, 32'h100, 1, 1, 1, 32'h80,  1);
    cyc(1, 32'h100, 32'h80, 0, 2'd0, 32'h100, 1, 1, 0, 32'h104, 1);
    cyc(1, 32'h100, 32'h80, 0, 2'd0, 32'h100, 1, 1, 0, 32'h104, 1);
    cyc(1, 32'h100, 32'h80, 1, 2'd0, 32'h100, 1, 1, 0, 32'h104, 1);
    cyc(1, 32'h100, 32'h80, 1, 2'd0, 32'h100, 1, 1, 0, 32'h104, 1);
    cyc(0, 0, 0, 0, 0,               32'h100, 1, 1, 1, 32'h80,  1);
    // aliasing at index 0
    cyc(1, 32'h140, 32'h300, 1, 2'd0, 32'h100, 1, 1, 1, 32'h80,  1);
    cyc(0, 0, 0, 0, 0,                32'h100, 1, 0, 0, 32'h104, 1);
    cyc(0, 0, 0, 0, 0,                32'h140, 1, 1, 1, 32'h300, 1);
    // call / return
    cyc(1, 32'h410, 32'h0,   0, 2'd3, 32'h410, 1, 0, 0, 32'h414, 1);
    cyc(1, 32'h200, 32'h400, 0, 2'd2, 32'h410, 1, 1, 0, 32'h414, 1);
    cyc(0, 0, 0, 0, 0,                32'h410, 1, 1, 1, 32'h204, 0);
    cyc(1, 32'h410, 32'h204, 0, 2'd3, 32'h200, 1, 1, 1, 32'h400, 0);
    cyc(0, 0, 0, 0, 0,                32'h410, 1, 1, 0, 32'h414, 1);
    // RAS overflow and underflow
    cyc(1, 32'h418, 32'h0, 0, 2'd3, 32'h418, 1, 0, 0, 32'h41C, 1);
    for (int k = 1; k <= 5; k++)
      cyc(1, 32'(k * 16), 32'h1000, 0, 2'd2, 32'h418, 0, 0, 0, 0, 0);
    cyc(1, 32'h418, 32'h0, 0, 2'd3, 32'h418, 1, 1, 1, 32'h54, 0);
    cyc(1, 32'h418, 32'h0, 0, 2'd3, 32'h418, 1, 1, 1, 32'h44, 0);
    cyc(1, 32'h418, 32'h0, 0, 2'd3, 32'h418, 1, 1, 1, 32'h34, 0);
    cyc(1, 32'h418, 32'h0, 0, 2'd3, 32'h418, 1, 1, 1, 32'h24, 0);
    cyc(1, 32'h418, 32'h0, 0, 2'd3, 32'h418, 1, 1, 0, 32'h41C, 1);
    cyc(1, 32'h60, 32'h1000, 0, 2'd2, 32'h418, 1, 1, 0, 32'h41C, 1);
    cyc(1, 32'h418, 32'h0, 0, 2'd3, 32'h418, 1, 1, 1, 32'h64, 0);
    cyc(0, 0, 0, 0, 0,                32'h418, 1, 1, 0, 32'h41C, 1);
    // asynchronous reset in the middle of an update
    cyc(1, 32'h100, 32'h80, 1, 2'd0, 32'h100, 1, 0, 0, 32'h104, 1);
    cyc(1, 32'h70, 32'h1000, 0, 2'd2, 32'h100, 1, 1, 1, 32'h80, 1);
    cyc(1, 32'h100, 32'h80, 1, 2'd0, 32'h100, 1, 0, 0, 32'h104, 1);
    #2 rst_n = 1'b0;
    cyc(0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 32'h104, 1);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 32'h104, 1);

    // randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = rand_pc();
      b = rand_pc();
      cyc(bit'($urandom_range(0, 1)), a, $urandom() & 32'hFFFF_FFFC,
          bit'($urandom_range(0, 1)), kind_of(a), b, 0, 0, 0, 0, 0);
    end

    @(posedge clk);
    #1 upd_en = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised next-PC predictor for the pipelined RISC-V core.
- IF stage looks up the current fetch PC combinationally. ID stage writes resolved branch/jump/call/return outcomes back.
- Structure: direct-mapped branch target buffer (BTB) with 2-bit saturating counters, plus a circular return address stack (RAS).
- Replaces the fixed predict-not-taken path; mispredict flushing stays with the hazard unit.

Parameters:
- XLEN, 32, PC/target width in bits.
- ENTRIES, 16, BTB entry count; power of 2, ≥2; IDX = log2(ENTRIES).
- RAS_DEPTH, 4, return address stack depth; ≥1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- pc_i  in  XLEN  fetch PC to predict.
- pred_taken_o  out  1  predicted redirect.
- pred_target_o  out  XLEN  predicted next PC.
- pred_hit_o  out  1  valid BTB tag match for pc_i.
- upd_en_i  in  1  resolved control-flow instruction, one-cycle strobe.
- upd_pc_i  in  XLEN  PC of resolved instruction.
- upd_target_i  in  XLEN  resolved target.
- upd_taken_i  in  1  resolved direction; ignored for kinds 01/10/11.
- upd_kind_i  in  2  00 branch, 01 jump, 10 call, 11 return.
- ras_empty_o  out  1  RAS count == 0.

Behaviour:
- Index = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]. PC bits [1:0] ignored.
- Entry fields: valid, tag, target[XLEN], kind[2], ctr[2].
- Reset (async, rst_i=0): all valid=0, ctr=01, RAS count=0, RAS pointer=0.
- Reset output values: pred_taken_o=0, pred_hit_o=0, ras_empty_o=1, pred_target_o=pc_i+4.
- Reset asserted mid-update discards that update.
- Lookup is combinational, zero latency; hit = valid && tag match.
- Prediction on hit:
  - kind 00: taken = ctr[1].
  - kind 01/10: taken = 1, target = entry target.
  - kind 11: taken = !ras_empty; target = RAS top.
- Not taken or miss: pred_target_o = pc_i+4, mod 2^XLEN (wraps at 0xFFFF_FFFC → 0).
- Update on rising edge when upd_en_i=1.
- Miss (or tag mismatch):
  - Allocate/overwrite: valid=1, tag, kind, target.
  - ctr = 10 if (kind==00 && taken) or kind!=00; else 01.
  - A not-taken branch still allocates, with ctr=01.
- Hit, kind 00:
  - Taken: ctr saturating increment (11 stays 11), target rewritten.
  - Not taken: ctr saturating decrement (00 stays 00), target kept.
- Hit, kind 01/10/11: target and kind rewritten, ctr=11.
- RAS push on kind 10: value upd_pc_i+4 at pointer; pointer increments modulo RAS_DEPTH.
  - count increments, saturating at RAS_DEPTH.
  - Push when full overwrites the oldest entry; count stays RAS_DEPTH.
- RAS pop on kind 11: pointer decrements modulo RAS_DEPTH; count decrements.
  - Pop when empty: no pointer/count change, no error.
- RAS top = slot at pointer-1.
- Same-cycle update and lookup to the same index: lookup returns pre-edge contents. No write-through bypass.
- Updates are trusted as in-order; no speculative RAS repair.
- Design is fully synchronous apart from reset. No X may propagate to outputs after reset.
- BTB storage is a flop array; no SRAM macro.

Test Plan:
- Reset, then pc_i=0x100 → pred_hit_o=0, pred_taken_o=0, pred_target_o=0x104, ras_empty_o=1.
- Branch counter training: update pc=0x100, kind=00, target=0x80, taken=1 → next cycle pc_i=0x100 gives hit=1, taken=1, target=0x80.
  - Then 3 not-taken updates: ctr 10→01→00→00; predictions taken=0, target=0x104.
  - Then 2 taken updates: taken=1 only after the second.
- Aliasing (ENTRIES=16): train pc=0x100, then update pc=0x140 (same index, different tag) → pc_i=0x100 misses (hit=0); pc_i=0x140 hits with new target.
- Call/return: call update pc=0x200 target=0x400; return update pc=0x410 after the BTB entry is allocated by a prior return.
  - Push 0x204 → lookup pc_i=0x410 gives taken=1, target=0x204.
  - Return update pops → ras_empty_o=1; next lookup gives taken=0, target=0x414.
- RAS overflow (RAS_DEPTH=4): calls at 0x10,0x20,0x30,0x40,0x50 → successive pops yield 0x54,0x44,0x34,0x24.
  - Fifth pop: empty, count stays 0.
- Async reset mid-update: assert rst_i low between edges while upd_en_i=1 → outputs reach reset values immediately; previously trained pc 0x100 misses after release.
